// File: rtl/uart_tx_fifo_param_if.sv
// rtl/uart_tx_fifo_param_if.sv - host write / serial status bundle for the FIFO-fed UART transmitter
interface uart_tx_fifo_param_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                 wr_en;
  logic [DATA_BITS-1:0] data_in;
  logic                 start_transmit;
  logic [1:0]           parity_mode;
  logic                 tx;
  logic                 busy;
  logic                 full;
  logic                 empty;
  logic [CNT_W-1:0]     fifo_count;
  logic                 overflow;

  modport master (
    output wr_en, data_in, start_transmit, parity_mode,
    input  tx, busy, full, empty, fifo_count, overflow
  );

  modport slave (
    input  wr_en, data_in, start_transmit, parity_mode,
    output tx, busy, full, empty, fifo_count, overflow
  );
endinterface

// File: rtl/uart_tx_fifo_param.sv
// rtl/uart_tx_fifo_param.sv - UART transmitter with integrated transmit FIFO
module uart_tx_fifo_param #(
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input logic clk,
  input logic reset_n,
  uart_tx_fifo_param_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 full_q, empty_q, overflow_q;

  state_t               state_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_en_q, par_bit_q;
  logic                 tx_q, busy_q;

  logic                 push, pop, bit_end, stop_end;
  logic [DATA_BITS-1:0] head;

  // full/empty are the registered pre-edge flags, so a write while full is
  // dropped even when a pop frees a slot in the same cycle
  assign head     = mem_q[rd_ptr_q];
  assign bit_end  = (bit_cnt_q == BIT_LAST);
  assign stop_end = (state_q == S_STOP) && bit_end && (idx_q == STOP_LAST);
  assign push     = bus.wr_en & ~full_q;
  assign pop      = bus.start_transmit & ~empty_q & ((state_q == S_IDLE) | stop_end);

  // Next occupancy from this cycle's push/pop pair
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  // FIFO storage; pointer reset alone discards anything written here
  always_ff @(posedge clk) begin
    if (reset_n && push) mem_q[wr_ptr_q] <= bus.data_in;
  end

  // FIFO pointers, occupancy and registered flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      full_q     <= (count_d == DEPTH_C);
      empty_q    <= (count_d == '0);
      overflow_q <= bus.wr_en & full_q;
    end
  end

  // Serialiser FSM; a pop can only happen in IDLE or on the last stop cycle,
  // so it is handled ahead of the per-state timing
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else if (pop) begin
      state_q   <= S_START;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      shift_q   <= head;
      par_en_q  <= (bus.parity_mode == 2'd1) || (bus.parity_mode == 2'd2);
      par_bit_q <= (^head) ^ (bus.parity_mode == 2'd2);
      tx_q      <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
        S_START: begin
          if (bit_end) begin
            bit_cnt_q <= '0;
            idx_q     <= '0;
            state_q   <= S_DATA;
            tx_q      <= shift_q[0];
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bit_cnt_q <= '0;
            shift_q   <= shift_q >> 1;
            if (idx_q == DATA_LAST) begin
              idx_q <= '0;
              if (par_en_q) begin
                state_q <= S_PARITY;
                tx_q    <= par_bit_q;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + IDX_W'(1);
              tx_q  <= shift_q[1];
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            bit_cnt_q <= '0;
            idx_q     <= '0;
            state_q   <= S_STOP;
            tx_q      <= 1'b1;
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            bit_cnt_q <= '0;
            if (idx_q == STOP_LAST) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              tx_q    <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// tb/tb_uart_tx_fifo_param.sv - self-checking bench for uart_tx_fifo_param
module tb_uart_tx_fifo_param;
  localparam int DB  = 8;
  localparam int FD  = 16;
  localparam int CPB = 4;
  localparam int TMO = 2000;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  uart_tx_fifo_param_if #(.DATA_BITS(DB), .FIFO_DEPTH(FD)) if1 ();
  uart_tx_fifo_param_if #(.DATA_BITS(DB), .FIFO_DEPTH(FD)) if2 ();

  uart_tx_fifo_param #(.DATA_BITS(DB), .FIFO_DEPTH(FD), .CLKS_PER_BIT(CPB), .STOP_BITS(1))
    dut1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));
  uart_tx_fifo_param #(.DATA_BITS(DB), .FIFO_DEPTH(FD), .CLKS_PER_BIT(CPB), .STOP_BITS(2))
    dut2 (.clk(clk), .reset_n(reset_n), .bus(if2.slave));

  int checks   = 0;
  int failures = 0;
  logic [7:0] words[$];

  typedef struct {
    logic       wr_en;
    logic [7:0] data;
    int         exp_count;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_ovf;
  } vec_t;
  vec_t vecs[18];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int frame_len(int pm, int stops);
    return (1 + DB + ((pm == 1 || pm == 2) ? 1 : 0) + stops) * CPB;
  endfunction

  // Expected line level for bit slot 'pos' of a frame: start, data LSB first, parity, stops
  function automatic logic frame_bit(logic [7:0] w, int pm, int pos);
    if (pos == 0) return 1'b0;
    if (pos <= DB) return w[pos-1];
    if ((pm == 1 || pm == 2) && pos == DB + 1) return (^w) ^ (pm == 2);
    return 1'b1;
  endfunction

  function automatic logic get_tx(int sel);
    return sel ? if2.tx : if1.tx;
  endfunction

  function automatic logic get_busy(int sel);
    return sel ? if2.busy : if1.busy;
  endfunction

  // Checks one whole frame; immediate=1 demands it begins on the very next cycle
  task automatic expect_frame(int sel, logic [7:0] w, int pm, int stops, bit immediate, string name);
    int waited = 0;
    int bad_tx = 0;
    int bad_busy = 0;
    int len = frame_len(pm, stops);
    if (immediate) begin
      @(negedge clk);
    end else begin
      while (get_tx(sel) !== 1'b0 && waited < TMO) begin
        @(negedge clk);
        waited++;
      end
      chk({name, "_start_seen"}, int'(waited < TMO), 1);
    end
    for (int c = 0; c < len; c++) begin
      if (c > 0) @(negedge clk);
      if (get_tx(sel) !== frame_bit(w, pm, c / CPB)) bad_tx++;
      if (get_busy(sel) !== 1'b1) bad_busy++;
    end
    chk({name, "_bit_errs"}, bad_tx, 0);
    chk({name, "_busy_errs"}, bad_busy, 0);
  endtask

  task automatic drive_wr(int sel, logic en, logic [7:0] d);
    if (sel) begin
      if2.wr_en = en; if2.data_in = d;
    end else begin
      if1.wr_en = en; if1.data_in = d;
    end
  endtask

  task automatic push_list(int sel);
    foreach (words[i]) begin
      @(negedge clk);
      drive_wr(sel, 1'b1, words[i]);
    end
    @(negedge clk);
    drive_wr(sel, 1'b0, 8'h00);
  endtask

  task automatic expect_list(int sel, int pm, int stops, string name);
    foreach (words[i])
      expect_frame(sel, words[i], pm, stops, i > 0, $sformatf("%s%0d", name, i));
  endtask

  task automatic wait_idle(int sel, string name);
    int n = 0;
    while (get_busy(sel) !== 1'b0 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle_seen"}, int'(n < TMO), 1);
  endtask

  initial begin
    if1.wr_en = 0; if1.data_in = 0; if1.start_transmit = 0; if1.parity_mode = 0;
    if2.wr_en = 0; if2.data_in = 0; if2.start_transmit = 0; if2.parity_mode = 0;
    reset_n = 0;

    // Reset with a write held active
    if1.wr_en = 1; if1.data_in = 8'd20;
    repeat (3) @(negedge clk);
    if1.wr_en = 0; reset_n = 1;
    @(negedge clk);
    chk("rst_tx", if1.tx, 1);
    chk("rst_busy", if1.busy, 0);
    chk("rst_empty", if1.empty, 1);
    chk("rst_full", if1.full, 0);
    chk("rst_count", if1.fifo_count, 0);
    chk("rst_ovf", if1.overflow, 0);
    chk("rst_tx2", if2.tx, 1);

    // Push into empty FIFO: pop one cycle later
    if1.start_transmit = 1; if1.wr_en = 1; if1.data_in = 8'h33;
    @(negedge clk);
    if1.wr_en = 0;
    chk("lat_tx_n", if1.tx, 1);
    chk("lat_busy_n", if1.busy, 0);
    chk("lat_count_n", if1.fifo_count, 1);
    chk("lat_empty_n", if1.empty, 0);
    @(negedge clk);
    chk("lat_tx_n1", if1.tx, 0);
    chk("lat_busy_n1", if1.busy, 1);
    chk("lat_count_n1", if1.fifo_count, 0);
    chk("lat_empty_n1", if1.empty, 1);
    wait_idle(0, "lat");

    // Even parity frame; parity_mode flipped mid-frame must not matter
    if1.parity_mode = 1;
    words = '{8'd20};
    fork
      push_list(0);
      expect_frame(0, 8'd20, 1, 1, 0, "even");
      begin repeat (20) @(negedge clk); if1.parity_mode = 2; end
    join
    @(negedge clk);
    chk("even_busy_after", if1.busy, 0);
    chk("even_tx_after", if1.tx, 1);
    if1.parity_mode = 0;

    // Odd parity, two stop bits
    if2.start_transmit = 1; if2.parity_mode = 2;
    fork
      push_list(1);
      expect_frame(1, 8'd20, 2, 2, 0, "odd2");
    join
    @(negedge clk);
    chk("odd2_busy_after", if2.busy, 0);

    // Back-to-back, no parity
    words = '{8'd20, 8'd40, 8'd60};
    fork
      push_list(0);
      expect_list(0, 0, 1, "b2b");
    join
    @(negedge clk);
    chk("b2b_busy_after", if1.busy, 0);
    chk("b2b_empty", if1.empty, 1);

    // Simultaneous push and pop leaves count unchanged
    if1.start_transmit = 0;
    @(negedge clk); drive_wr(0, 1, 8'h11);
    @(negedge clk); drive_wr(0, 1, 8'h22);
    @(negedge clk); drive_wr(0, 1, 8'h44);
    chk("sim_count_pre", if1.fifo_count, 2);
    if1.start_transmit = 1;
    @(negedge clk); drive_wr(0, 0, 8'h00);
    chk("sim_count_post", if1.fifo_count, 2);
    words = '{8'h11, 8'h22, 8'h44};
    expect_list(0, 0, 1, "sim");
    @(negedge clk);
    chk("sim_empty", if1.empty, 1);

    // Fill to full and overflow, table driven
    if1.start_transmit = 0;
    for (int i = 0; i < 18; i++) begin
      vecs[i].wr_en     = (i < 17);
      vecs[i].data      = 8'((i + 1) * 20);
      vecs[i].exp_count = (i + 1 < FD) ? i + 1 : FD;
      vecs[i].exp_full  = (i + 1 >= FD);
      vecs[i].exp_empty = 1'b0;
      vecs[i].exp_ovf   = (i == 16);
    end
    for (int i = 0; i < 18; i++) begin
      drive_wr(0, vecs[i].wr_en, vecs[i].data);
      @(negedge clk);
      chk($sformatf("tbl%0d_count", i), if1.fifo_count, vecs[i].exp_count);
      chk($sformatf("tbl%0d_full", i), if1.full, vecs[i].exp_full);
      chk($sformatf("tbl%0d_empty", i), if1.empty, vecs[i].exp_empty);
      chk($sformatf("tbl%0d_ovf", i), if1.overflow, vecs[i].exp_ovf);
    end
    words.delete();
    for (int i = 0; i < FD; i++) words.push_back(vecs[i].data);
    if1.start_transmit = 1;
    expect_list(0, 0, 1, "drain");
    @(negedge clk);
    chk("drain_busy_after", if1.busy, 0);
    chk("drain_count", if1.fifo_count, 0);

    // Randomized batches against the frame model
    for (int b = 0; b < 6; b++) begin
      int n = $urandom_range(1, 5);
      int pm = $urandom_range(0, 3);
      if1.parity_mode = 2'(pm);
      words.delete();
      for (int k = 0; k < n; k++) words.push_back(8'($urandom));
      fork
        push_list(0);
        expect_list(0, pm, 1, $sformatf("rnd%0d_", b));
      join
      @(negedge clk);
      chk($sformatf("rnd%0d_busy_after", b), if1.busy, 0);
      chk($sformatf("rnd%0d_count", b), if1.fifo_count, 0);
    end
    if1.parity_mode = 0;

    // Reset during DATA of a frame aborts it
    @(negedge clk); drive_wr(0, 1, 8'd200);
    @(negedge clk); drive_wr(0, 0, 8'h00);
    begin
      int n = 0;
      while (if1.tx !== 1'b0 && n < TMO) begin @(negedge clk); n++; end
      chk("abort_start_seen", int'(n < TMO), 1);
    end
    repeat (CPB * 3) @(negedge clk);
    chk("abort_in_frame", if1.busy, 1);
    reset_n = 0;
    @(negedge clk);
    chk("abort_tx", if1.tx, 1);
    chk("abort_busy", if1.busy, 0);
    chk("abort_count", if1.fifo_count, 0);
    @(negedge clk);
    chk("abort_tx_hold", if1.tx, 1);
    reset_n = 1;
    @(negedge clk);
    words = '{8'h5A};
    fork
      push_list(0);
      expect_frame(0, 8'h5A, 0, 1, 0, "post_abort");
    join
    @(negedge clk);
    chk("post_abort_busy", if1.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
